pkt_stream_sched: RTL and testbench
===================================

Name: pkt_stream_sched

Overview:
- Packet-granular scheduler that shares one packet_data datapath between NUM_SRC AXI-stream sources.
- Arbitrates round-robin on packet boundaries and muxes the granted source onto the datapath's slave side.
- Drives the datapath's packet_config from per-source config registers, held stable for the whole packet.
- Enforces the configured packet length: over-length packets are truncated and the excess beats are dropped.

Parameters:
DATA_WIDTH, 8, beat width; also the width of each half of the config word (k, len)
NUM_SRC, 4, number of requesting sources (2..8)
SEL_W, $clog2(NUM_SRC), width of source index fields

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source beats, source i at [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tvalid  in  NUM_SRC  per-source valid
s_axis_tlast  in  NUM_SRC  per-source end of packet
s_axis_tready  out  NUM_SRC  per-source ready
cfg_wr_en  in  1  config register write strobe
cfg_wr_sel  in  SEL_W  source index for the config write
cfg_wr_data  in  2*DATA_WIDTH  {k, len} for that source
m_axis_tdata  out  DATA_WIDTH  to datapath s_axis_tdata
m_axis_tvalid  out  1  to datapath s_axis_tvalid
m_axis_tlast  out  1  to datapath s_axis_tlast
m_axis_tready  in  1  from datapath s_axis_tready
packet_config  out  2*DATA_WIDTH  {k, len} of the granted source, to datapath
grant_id  out  SEL_W  currently or most recently granted source
busy  out  1  high in PASS or DROP
len_err  out  NUM_SRC  sticky per-source truncation flag

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all cfg registers, packet_config, grant_id, len_err, beat_cnt cleared to 0.
  - last_grant=NUM_SRC-1, so source 0 wins first.
  - Outputs s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0.
  - Reset mid-packet abandons the packet immediately; no tlast is emitted.
- FSM states: IDLE, PASS, DROP.
- IDLE:
  - All s_axis_tready=0, m_axis_tvalid=0.
  - If any s_axis_tvalid is high, pick the first requester searching last_grant+1, +2, ... (mod NUM_SRC).
  - Register grant_id, last_grant and packet_config<=cfg[grant]; clear beat_cnt; go to PASS.
  - Arbitration costs one bubble cycle; the first beat can transfer in the cycle after the grant.
- PASS (combinational mux, zero added latency):
  - m_axis_tdata/tvalid come from source g; s_axis_tready[g]=m_axis_tready; all other s_axis_tready=0.
  - A beat is accepted when m_axis_tvalid & m_axis_tready; beat_cnt increments on each accepted beat.
  - m_axis_tlast = s_axis_tlast[g] | (len!=0 & beat_cnt==len-1).
  - Accepted beat with source tlast: go to IDLE.
  - Accepted beat with forced tlast but no source tlast: set len_err[g]; go to DROP.
- DROP:
  - s_axis_tready[g]=1; m_axis_tvalid=0.
  - Discard source beats until a beat with s_axis_tlast[g]=1 is accepted, then go to IDLE.
- len==0 means no length limit; k is passed through untouched.
- Short packets (tlast before len beats) pass unmodified with no error.
- Config writes:
  - A write updates cfg[cfg_wr_sel] on the clock edge and clears len_err[cfg_wr_sel].
  - A write to the granted source mid-packet does not change packet_config until that source's next grant.
  - If a write and a set of len_err for the same source occur in the same cycle, the set wins.
- Fairness: a source requesting continuously is granted at least once every NUM_SRC packets.
- Datapath full is handled by the datapath deasserting m_axis_tready; the scheduler only stalls and never drops beats in PASS.
- beat_cnt is DATA_WIDTH bits; it saturates, never wraps, when len==0.

Optional Feature:
- Macro: PKT_SCHED_STRICT_PRIO_EN.
- Defined: IDLE grants the lowest-index requesting source (fixed priority); last_grant is unused.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then sources 0 and 2 each present a 4-beat packet, cfg len=0, m_axis_tready=1 -> source 0 packet out first with tlast on beat 4; 1 idle cycle; then source 2; grant_id sequence 0,2.
- cfg src1 {k=2,len=5}; src1 sends 8 beats 0x10..0x17 -> out 0x10..0x14 with tlast on 0x14; 0x15..0x17 consumed with no m_axis_tvalid; len_err[1]=1; packet_config=0x0205 throughout.
- All 4 sources continuously valid, 3-beat packets -> grants 0,1,2,3,0,1 in round-robin order; each packet contiguous.
- m_axis_tready toggled 1,0,0,1 during a 4-beat packet from src3 -> s_axis_tready[3] follows it; no beat lost or duplicated; data order preserved.
- Write cfg src0 {1,3} during src0's packet granted with {0,6} -> packet_config stays 0x0006 until tlast; next src0 grant shows 0x0103.
- rst asserted on beat 2 of a PASS packet -> outputs 0 asynchronously, state IDLE; after release, source 0 wins first regardless of the previous grant.

Source files
------------

// File: rtl/pkt_stream_sched.sv
// pkt_stream_sched: shares one packet datapath between NUM_SRC AXI-stream
// sources. Arbitration happens only on packet boundaries; the granted
// source's {k, len} config is latched at grant and held for the whole packet.
// Packets longer than len are cut at len beats and the remainder is drained.
// Optional build macro PKT_SCHED_STRICT_PRIO_EN selects fixed lowest-index
// priority instead of round-robin.
module pkt_stream_sched #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SRC    = 4,
   parameter int SEL_W      = $clog2(NUM_SRC)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]            s_axis_tvalid,
   input  logic [NUM_SRC-1:0]            s_axis_tlast,
   output logic [NUM_SRC-1:0]            s_axis_tready,
   input  logic                          cfg_wr_en,
   input  logic [SEL_W-1:0]              cfg_wr_sel,
   input  logic [2*DATA_WIDTH-1:0]       cfg_wr_data,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   input  logic                          m_axis_tready,
   output logic [2*DATA_WIDTH-1:0]       packet_config,
   output logic [SEL_W-1:0]              grant_id,
   output logic                          busy,
   output logic [NUM_SRC-1:0]            len_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam logic [DATA_WIDTH-1:0] CNT_MAX = {DATA_WIDTH{1'b1}};

   state_t                    state_q, state_d;
   logic [2*DATA_WIDTH-1:0]   cfg_q [NUM_SRC];
   logic [2*DATA_WIDTH-1:0]   pcfg_q;
   logic [SEL_W-1:0]          grant_q;
   logic [SEL_W-1:0]          last_q;
   logic [NUM_SRC-1:0]        len_err_q, len_err_d;
   logic [DATA_WIDTH-1:0]     beat_cnt_q;

   logic [SEL_W-1:0]          pick;
   logic                      any_req;
   logic [DATA_WIDTH-1:0]     g_data;
   logic                      g_valid;
   logic                      g_last;
   logic [DATA_WIDTH-1:0]     pkt_len;
   logic                      force_last;
   logic                      accept;
   logic                      set_err;
   logic                      grant_now;
   logic                      wr_ok;

   // Granted source's stream, muxed with zero added latency.
   assign g_data  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
   assign g_valid = s_axis_tvalid[grant_q];
   assign g_last  = s_axis_tlast[grant_q];

   // len==0 disables the limit; otherwise the len-th beat is forced to be last.
   assign pkt_len    = pcfg_q[DATA_WIDTH-1:0];
   assign force_last = (pkt_len != '0) && (beat_cnt_q == pkt_len - 1'b1);

   assign accept    = (state_q == PASS) && g_valid && m_axis_tready;
   assign set_err   = accept && !g_last && force_last;
   assign grant_now = (state_q == IDLE) && any_req;
   assign wr_ok     = cfg_wr_en && (int'(cfg_wr_sel) < NUM_SRC);

`ifdef PKT_SCHED_STRICT_PRIO_EN
   // Fixed priority: lowest-index requester wins.
   always_comb begin
      pick    = '0;
      any_req = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!any_req && s_axis_tvalid[i]) begin
            any_req = 1'b1;
            pick    = SEL_W'(i);
         end
      end
   end
`else
   // Round-robin: first requester after the previous grant, wrapping.
   always_comb begin
      int idx;
      pick    = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         idx = int'(last_q) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         if (!any_req && s_axis_tvalid[idx]) begin
            any_req = 1'b1;
            pick    = SEL_W'(idx);
         end
      end
   end
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state: grant in IDLE, leave PASS on source or forced tlast,
   // leave DROP once the source's own tlast has been drained.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (any_req) state_d = PASS;
         PASS: begin
            if (accept) begin
               if (g_last)          state_d = IDLE;
               else if (force_last) state_d = DROP;
            end
         end
         DROP: if (g_valid && g_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: only the granted source ever sees tready.
   always_comb begin
      s_axis_tready = '0;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      case (state_q)
         PASS: begin
            m_axis_tdata           = g_data;
            m_axis_tvalid          = g_valid;
            m_axis_tlast           = g_last | force_last;
            s_axis_tready[grant_q] = m_axis_tready;
         end
         DROP: s_axis_tready[grant_q] = 1'b1;
         default: ;
      endcase
   end

   // Sticky truncation flags: a config write clears, a truncation sets,
   // and the set takes precedence when both hit the same source.
   always_comb begin
      len_err_d = len_err_q;
      if (wr_ok)   len_err_d[cfg_wr_sel] = 1'b0;
      if (set_err) len_err_d[grant_q]    = 1'b1;
   end

   // Grant bookkeeping, per-packet config latch, beat counter, config file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SRC; i++) cfg_q[i] <= '0;
         pcfg_q     <= '0;
         grant_q    <= '0;
         last_q     <= SEL_W'(NUM_SRC - 1);
         len_err_q  <= '0;
         beat_cnt_q <= '0;
      end else begin
         len_err_q <= len_err_d;
         // pcfg_q samples the pre-write config, so a same-cycle write to the
         // picked source only shows at its next grant.
         if (grant_now) begin
            grant_q    <= pick;
            last_q     <= pick;
            pcfg_q     <= cfg_q[pick];
            beat_cnt_q <= '0;
         end else if (accept && beat_cnt_q != CNT_MAX) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
         end
         if (wr_ok) cfg_q[cfg_wr_sel] <= cfg_wr_data;
      end
   end

   assign packet_config = pcfg_q;
   assign grant_id      = grant_q;
   assign busy          = (state_q != IDLE);
   assign len_err       = len_err_q;

endmodule

// File: tb/tb_pkt_stream_sched.sv
// Bench for pkt_stream_sched: queued source packets, a packet-level
// reference model of arbitration and truncation, beat-by-beat comparison.
`timescale 1ns/1ps
module tb_pkt_stream_sched;
   localparam int DW   = 8;
   localparam int NS   = 4;
   localparam int SW   = 2;
   localparam int MAXB = 64;

   typedef struct packed {
      logic [DW-1:0]   d;
      logic            l;
      logic [SW-1:0]   g;
      logic [2*DW-1:0] c;
   } obeat_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [NS*DW-1:0]  s_data;
   logic [NS-1:0]     s_valid, s_last, s_ready;
   logic              cfg_wr_en;
   logic [SW-1:0]     cfg_wr_sel;
   logic [2*DW-1:0]   cfg_wr_data;
   logic [DW-1:0]     m_data;
   logic              m_valid, m_last, m_ready;
   logic [2*DW-1:0]   packet_config;
   logic [SW-1:0]     grant_id;
   logic              busy;
   logic [NS-1:0]     len_err;

   pkt_stream_sched #(.DATA_WIDTH(DW), .NUM_SRC(NS), .SEL_W(SW)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
      .s_axis_tready(s_ready),
      .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel), .cfg_wr_data(cfg_wr_data),
      .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last),
      .m_axis_tready(m_ready),
      .packet_config(packet_config), .grant_id(grant_id), .busy(busy),
      .len_err(len_err)
   );

   always #5 clk = ~clk;

   int              n_tests = 0;
   int              n_fail  = 0;
   int              cyc     = 0;
   logic [DW-1:0]   bdata [NS][MAXB];
   logic            blast [NS][MAXB];
   int              bcnt  [NS];
   int              bptr  [NS];
   obeat_t          got_q [$];
   int              got_t [$];
   obeat_t          exp_q [$];
   logic [2*DW-1:0] cfg_m [NS];
   logic [NS-1:0]   err_m;
   int              mlast;
   bit              rnd_ready;
   bit              wr_pend;
   logic [SW-1:0]   wr_sel_p;
   logic [2*DW-1:0] wr_data_p;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic add_pkt(input int src, input int n, input int base);
      for (int j = 0; j < n; j++) begin
         bdata[src][bcnt[src]] = DW'(base + j);
         blast[src][bcnt[src]] = (j == n - 1);
         bcnt[src]++;
      end
   endtask

   task automatic drive_srcs();
      for (int i = 0; i < NS; i++) begin
         if (bptr[i] < bcnt[i]) begin
            s_valid[i]          = 1'b1;
            s_data[i*DW +: DW]  = bdata[i][bptr[i]];
            s_last[i]           = blast[i][bptr[i]];
         end else begin
            s_valid[i]          = 1'b0;
            s_data[i*DW +: DW]  = '0;
            s_last[i]           = 1'b0;
         end
      end
   endtask

   // One clock: sample handshakes at negedge, update drivers just after posedge.
   task automatic cycle();
      logic [NS-1:0] fire;
      obeat_t        b;
      @(negedge clk);
      cyc++;
      fire = s_valid & s_ready;
      if (m_valid && m_ready) begin
         b.d = m_data; b.l = m_last; b.g = grant_id; b.c = packet_config;
         got_q.push_back(b);
         got_t.push_back(cyc);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) if (fire[i]) bptr[i]++;
      drive_srcs();
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wr_pend) begin
         cfg_wr_en = 1'b1; cfg_wr_sel = wr_sel_p; cfg_wr_data = wr_data_p; wr_pend = 0;
      end else begin
         cfg_wr_en = 1'b0;
      end
   endtask

   task automatic set_cfg(input int sel, input logic [2*DW-1:0] data);
      wr_sel_p = SW'(sel); wr_data_p = data; wr_pend = 1;
      cfg_m[sel] = data; err_m[sel] = 1'b0;
      cycle();
      cycle();
   endtask

   // Packet-level model: with every pending source continuously valid, the
   // grant order is the arbitration rule over sources that still hold data.
   task automatic model_run();
      int     p [NS];
      int     s, n, len;
      bit     pkt_done;
      obeat_t b;
      for (int i = 0; i < NS; i++) p[i] = bptr[i];
      s = 0;
      while (s >= 0) begin
         s = -1;
`ifdef PKT_SCHED_STRICT_PRIO_EN
         for (int i = NS - 1; i >= 0; i--) if (p[i] < bcnt[i]) s = i;
`else
         for (int k = NS; k >= 1; k--) if (p[(mlast + k) % NS] < bcnt[(mlast + k) % NS]) s = (mlast + k) % NS;
`endif
         if (s >= 0) begin
            mlast = s;
            len = int'(cfg_m[s][DW-1:0]);
            n = 0;
            pkt_done = 0;
            while (!pkt_done) begin
               if (len == 0 || n < len) begin
                  b.d = bdata[s][p[s]];
                  b.l = blast[s][p[s]] || (n == len - 1);
                  b.g = SW'(s);
                  b.c = cfg_m[s];
                  exp_q.push_back(b);
               end
               if (len != 0 && n == len - 1 && !blast[s][p[s]]) err_m[s] = 1'b1;
               pkt_done = blast[s][p[s]];
               n++;
               p[s]++;
            end
         end
      end
   endtask

   task automatic run_scn(input string tag, input int wr_at);
      int k;
      bit done, empty;
      got_q.delete(); got_t.delete(); exp_q.delete();
      model_run();
      drive_srcs();
      k = 0; done = 0;
      while (!done && k < 3000) begin
         if (k == wr_at) begin
            wr_pend = 1;
            cfg_m[wr_sel_p] = wr_data_p;
            err_m[wr_sel_p] = 1'b0;
         end
         cycle();
         k++;
         empty = 1;
         for (int i = 0; i < NS; i++) if (bptr[i] < bcnt[i]) empty = 0;
         done = empty && !busy;
      end
      check({tag, " done"}, 64'(done), 64'd1);
      check({tag, " beat count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, " beat"}, 64'(got_q[i]), 64'(exp_q[i]));
      check({tag, " len_err"}, 64'(len_err), 64'(err_m));
      for (int i = 0; i < NS; i++) begin bcnt[i] = 0; bptr[i] = 0; end
      drive_srcs();
   endtask

   initial begin
      int c0;
      rst = 1'b1; s_data = '0; s_valid = '0; s_last = '0; m_ready = 1'b1;
      cfg_wr_en = 1'b0; cfg_wr_sel = '0; cfg_wr_data = '0;
      rnd_ready = 0; wr_pend = 0; wr_sel_p = '0; wr_data_p = '0;
      for (int i = 0; i < NS; i++) begin bcnt[i] = 0; bptr[i] = 0; cfg_m[i] = '0; end
      err_m = '0; mlast = NS - 1;
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", 64'(busy), 64'd0);
      check("rst m_valid", 64'(m_valid), 64'd0);
      check("rst m_last", 64'(m_last), 64'd0);
      check("rst m_data", 64'(m_data), 64'd0);
      check("rst s_ready", 64'(s_ready), 64'd0);
      check("rst grant_id", 64'(grant_id), 64'd0);
      check("rst packet_config", 64'(packet_config), 64'd0);
      check("rst len_err", 64'(len_err), 64'd0);
      rst = 1'b0;
      cycle();

      // Two sources, no limit: src0 first, one bubble, then src2.
      add_pkt(0, 4, 'h00); add_pkt(2, 4, 'h20);
      c0 = cyc;
      run_scn("rr2", -1);
      if (got_t.size() >= 5) begin
         check("rr2 first beat latency", 64'(got_t[0] - c0), 64'd2);
         check("rr2 bubble", 64'(got_t[4] - got_t[3]), 64'd2);
      end

      // Truncation at len=5.
      set_cfg(1, 16'h0205);
      add_pkt(1, 8, 'h10);
      run_scn("trunc", -1);
      check("trunc len_err[1]", 64'(len_err[1]), 64'd1);
      check("trunc packet_config", 64'(packet_config), 64'h0205);

      // All four sources back to back.
      for (int i = 0; i < NS; i++) begin add_pkt(i, 3, i * 16); add_pkt(i, 3, i * 16 + 8); end
      run_scn("rr4", -1);

      // Backpressure on a single packet.
      rnd_ready = 1;
      add_pkt(3, 4, 'h30);
      run_scn("stall", -1);
      rnd_ready = 0;

      // Config write while the source's packet is in flight.
      set_cfg(0, 16'h0006);
      check("cfg write clears len_err", 64'(len_err), 64'(err_m));
      add_pkt(0, 5, 'h40);
      wr_sel_p = '0; wr_data_p = 16'h0103;
      run_scn("cfgmid", 2);
      check("cfgmid packet_config held", 64'(packet_config), 64'h0006);
      add_pkt(0, 5, 'h50);
      run_scn("cfgnext", -1);
      check("cfgnext packet_config", 64'(packet_config), 64'h0103);

      // Randomized rounds.
      rnd_ready = 1;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NS; i++)
            set_cfg(i, {8'($urandom_range(0, 255)), 8'($urandom_range(0, 6))});
         for (int i = 0; i < NS; i++) begin
            int np;
            np = $urandom_range(0, 3);
            for (int j = 0; j < np; j++) add_pkt(i, $urandom_range(1, 8), $urandom_range(0, 255));
         end
         run_scn("rand", -1);
      end
      rnd_ready = 0;

      // Reset in the middle of a packet.
      got_q.delete(); got_t.delete();
      add_pkt(2, 6, 'h60);
      drive_srcs();
      for (int k = 0; k < 20 && got_q.size() < 1; k++) cycle();
      check("midrst busy before", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check("midrst m_valid", 64'(m_valid), 64'd0);
      check("midrst m_last", 64'(m_last), 64'd0);
      check("midrst m_data", 64'(m_data), 64'd0);
      check("midrst busy", 64'(busy), 64'd0);
      check("midrst s_ready", 64'(s_ready), 64'd0);
      check("midrst grant_id", 64'(grant_id), 64'd0);
      check("midrst packet_config", 64'(packet_config), 64'd0);
      for (int i = 0; i < NS; i++) begin bcnt[i] = 0; bptr[i] = 0; cfg_m[i] = '0; end
      err_m = '0; mlast = NS - 1;
      drive_srcs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle();
      add_pkt(3, 2, 'h70); add_pkt(0, 2, 'h78);
      run_scn("postrst", -1);
      if (got_q.size() >= 1) check("postrst first grant", 64'(got_q[0].g), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
